// File: rtl/sprite_layer_compositor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sprite_layer_compositor: 3-stage sprite-over-scrolling-background mixer     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sprite_layer_compositor #(
   parameter int NUM_SPRITES = 4,
   parameter int SPR_W       = 34,
   parameter int SPR_H       = 24,
   parameter int SCREEN_W    = 640,
   parameter int SCREEN_H    = 480,
   parameter int BG_W        = 260,
   parameter int CIDX_W      = 6,
   parameter int SCROLL_DIV  = 50000,
   localparam int ADDR_W     = $clog2(SPR_W*SPR_H)
) (
   input  logic                          iClock,
   input  logic                          iReset,
   input  logic                          iValid,
   input  logic [9:0]                    iX,
   input  logic [9:0]                    iY,
   input  logic                          iFrameStart,
   input  logic                          iAttrWe,
   input  logic [2:0]                    iAttrSel,
   input  logic signed [10:0]            iAttrX,
   input  logic signed [10:0]            iAttrY,
   input  logic                          iAttrEn,
   output logic [NUM_SPRITES*ADDR_W-1:0] oSprAddr,
   input  logic [NUM_SPRITES*CIDX_W-1:0] iSprCidx,
   output logic [16:0]                   oBgAddr,
   input  logic [CIDX_W-1:0]             iBgCidx,
   output logic                          oValid,
   output logic [CIDX_W-1:0]             oCidx,
   output logic [9:0]                    oX,
   output logic [9:0]                    oY,
   output logic                          oCollision
);

   localparam int c_SCR_W = $clog2(BG_W + 1);
   localparam int c_DIV_W = $clog2(SCROLL_DIV + 1);
   localparam logic signed [11:0] c_SPR_W12 = 12'(SPR_W);
   localparam logic signed [11:0] c_SPR_H12 = 12'(SPR_H);
   localparam logic [23:0]        c_SPR_W24 = 24'(SPR_W);
   localparam logic [16:0]        c_BG_W17  = 17'(BG_W);
   localparam logic [c_SCR_W-1:0] c_BG_LAST  = c_SCR_W'(BG_W - 1);
   localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCROLL_DIV - 1);

   logic [NUM_SPRITES-1:0] r_sh_en, r_act_en, w_nx_en;
   logic signed [10:0]     r_sh_x  [NUM_SPRITES];
   logic signed [10:0]     r_sh_y  [NUM_SPRITES];
   logic signed [10:0]     r_act_x [NUM_SPRITES];
   logic signed [10:0]     r_act_y [NUM_SPRITES];
   logic signed [10:0]     w_nx_x  [NUM_SPRITES];
   logic signed [10:0]     w_nx_y  [NUM_SPRITES];

   // Next shadow value, so a write landing on iFrameStart reaches the active set too
   always_comb begin
      w_nx_en = r_sh_en;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         w_nx_x[i] = r_sh_x[i];
         w_nx_y[i] = r_sh_y[i];
         if (iAttrWe && (iAttrSel == 3'(i))) begin
            w_nx_en[i] = iAttrEn;
            w_nx_x[i]  = iAttrX;
            w_nx_y[i]  = iAttrY;
         end
      end
   end

   always_ff @(posedge iClock) begin
      if (iReset) begin
         r_sh_en  <= '0;
         r_act_en <= '0;
         for (int i = 0; i < NUM_SPRITES; i++) begin
            r_sh_x[i]  <= '0;
            r_sh_y[i]  <= '0;
            r_act_x[i] <= '0;
            r_act_y[i] <= '0;
         end
      end else begin
         r_sh_en <= w_nx_en;
         for (int i = 0; i < NUM_SPRITES; i++) begin
            r_sh_x[i] <= w_nx_x[i];
            r_sh_y[i] <= w_nx_y[i];
         end
         if (iFrameStart) begin
            r_act_en <= w_nx_en;
            for (int i = 0; i < NUM_SPRITES; i++) begin
               r_act_x[i] <= w_nx_x[i];
               r_act_y[i] <= w_nx_y[i];
            end
         end
      end
   end

   logic                          w_on;
   logic signed [11:0]            w_px, w_py;
   logic [NUM_SPRITES-1:0]        w_hit;
   logic [NUM_SPRITES*ADDR_W-1:0] w_spr_addr;

   assign w_on = ({1'b0, iX} < 11'(SCREEN_W)) && ({1'b0, iY} < 11'(SCREEN_H));
   assign w_px = signed'({2'b00, iX});
   assign w_py = signed'({2'b00, iY});

   // Offsets are signed at 12 bits so negative or off-screen sprites clip instead of wrapping
   for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_spr
      logic signed [11:0] w_dx, w_dy;
      logic [ADDR_W-1:0]  w_lin;
      assign w_dx = w_px - signed'({r_act_x[g][10], r_act_x[g]});
      assign w_dy = w_py - signed'({r_act_y[g][10], r_act_y[g]});
      assign w_hit[g] = w_on && r_act_en[g] &&
                        (w_dx >= 12'sd0) && (w_dx < c_SPR_W12) &&
                        (w_dy >= 12'sd0) && (w_dy < c_SPR_H12);
      assign w_lin = ADDR_W'(({12'd0, w_dy} * c_SPR_W24) + {12'd0, w_dx});
      assign w_spr_addr[g*ADDR_W +: ADDR_W] = w_hit[g] ? w_lin : '0;
   end

   logic [c_SCR_W-1:0] r_scroll;
   logic [c_DIV_W-1:0] r_div;
   logic               r_pend, w_step;
   logic [16:0]        w_bgx, w_bg;

   assign w_step = (r_div == c_DIV_LAST);
   assign w_bgx  = (17'(iX) + 17'(r_scroll)) % c_BG_W17;
   assign w_bg   = w_bgx + 17'(iY) * c_BG_W17;

   // Scroll steps are banked and only applied at a frame boundary to avoid tearing
   always_ff @(posedge iClock) begin
      if (iReset) begin
         r_div    <= '0;
         r_pend   <= 1'b0;
         r_scroll <= '0;
      end else begin
         r_div <= w_step ? '0 : r_div + 1'b1;
         if (iFrameStart) begin
            r_pend <= 1'b0;
            if (r_pend || w_step)
               r_scroll <= (r_scroll == c_BG_LAST) ? '0 : r_scroll + 1'b1;
         end else begin
            r_pend <= r_pend | w_step;
         end
      end
   end

   logic                   r_s1_valid, r_s2_valid;
   logic [NUM_SPRITES-1:0] r_s1_hit, r_s2_hit;
   logic [9:0]             r_s1_x, r_s1_y, r_s2_x, r_s2_y;

   always_ff @(posedge iClock) begin
      if (iReset) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
         r_s1_hit   <= '0;
         r_s2_hit   <= '0;
         r_s1_x     <= '0;
         r_s1_y     <= '0;
         r_s2_x     <= '0;
         r_s2_y     <= '0;
         oSprAddr   <= '0;
         oBgAddr    <= '0;
      end else begin
         r_s1_valid <= iValid;
         r_s1_hit   <= w_hit;
         r_s1_x     <= iX;
         r_s1_y     <= iY;
         oSprAddr   <= w_spr_addr;
         oBgAddr    <= w_bg;
         r_s2_valid <= r_s1_valid;
         r_s2_hit   <= r_s1_hit;
         r_s2_x     <= r_s1_x;
         r_s2_y     <= r_s1_y;
      end
   end

   logic [CIDX_W-1:0]      w_cidx;
   logic [NUM_SPRITES-1:0] w_nz;
   logic                   w_found, w_other, w_coll;

   // Lowest-index opaque sprite wins; colour 0 is see-through
   always_comb begin
      w_cidx  = iBgCidx;
      w_found = 1'b0;
      w_other = 1'b0;
      w_nz    = '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         w_nz[i] = r_s2_hit[i] && (iSprCidx[i*CIDX_W +: CIDX_W] != '0);
         if (w_nz[i] && !w_found) begin
            w_cidx  = iSprCidx[i*CIDX_W +: CIDX_W];
            w_found = 1'b1;
         end
         if (i > 0)
            w_other = w_other | w_nz[i];
      end
   end

   assign w_coll = r_s2_valid && w_nz[0] && w_other;

   logic r_coll_flag;

   always_ff @(posedge iClock) begin
      if (iReset) begin
         oValid      <= 1'b0;
         oCidx       <= '0;
         oX          <= '0;
         oY          <= '0;
         oCollision  <= 1'b0;
         r_coll_flag <= 1'b0;
      end else begin
         oValid <= r_s2_valid;
         if (r_s2_valid) begin
            oCidx <= w_cidx;
            oX    <= r_s2_x;
            oY    <= r_s2_y;
         end
         if (iFrameStart) begin
            oCollision  <= r_coll_flag;
            r_coll_flag <= w_coll;
         end else begin
            r_coll_flag <= r_coll_flag | w_coll;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sprite_layer_compositor.sv
`default_nettype none
// Directed scoreboard bench for sprite_layer_compositor; pixelmap data = fill + address.
module tb_sprite_layer_compositor;

   localparam int N  = 4;
   localparam int SW = 34;
   localparam int SH = 24;
   localparam int CW = 6;
   localparam int AW = $clog2(SW*SH);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic                 iValid, iFrameStart, iAttrWe, iAttrEn;
   logic [9:0]           iX, iY;
   logic [2:0]           iAttrSel;
   logic signed [10:0]   iAttrX, iAttrY;
   logic [N*AW-1:0]      oSprAddr;
   logic [N*CW-1:0]      iSprCidx;
   logic [16:0]          oBgAddr;
   logic [CW-1:0]        iBgCidx;
   logic                 oValid, oCollision;
   logic [CW-1:0]        oCidx;
   logic [9:0]           oX, oY;

   sprite_layer_compositor #(
      .NUM_SPRITES(N), .SPR_W(SW), .SPR_H(SH), .SCREEN_W(640), .SCREEN_H(480),
      .BG_W(260), .CIDX_W(CW), .SCROLL_DIV(4)
   ) dut (
      .iClock(clk), .iReset(rst), .iValid(iValid), .iX(iX), .iY(iY),
      .iFrameStart(iFrameStart), .iAttrWe(iAttrWe), .iAttrSel(iAttrSel),
      .iAttrX(iAttrX), .iAttrY(iAttrY), .iAttrEn(iAttrEn),
      .oSprAddr(oSprAddr), .iSprCidx(iSprCidx), .oBgAddr(oBgAddr), .iBgCidx(iBgCidx),
      .oValid(oValid), .oCidx(oCidx), .oX(oX), .oY(oY), .oCollision(oCollision)
   );

   logic [CW-1:0] spr_fill [N];
   logic [CW-1:0] spr_q    [N];

   always @(posedge clk) begin
      for (int i = 0; i < N; i++)
         spr_q[i] <= (spr_fill[i] == '0) ? '0 : CW'(spr_fill[i] + oSprAddr[i*AW +: CW]);
      iBgCidx <= 6'd3;
   end

   for (genvar g = 0; g < N; g++) begin : g_mem
      assign iSprCidx[g*CW +: CW] = spr_q[g];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [5:0]  c;
      logic [9:0]  x;
      logic [9:0]  y;
      logic [31:0] t;
   } exp_t;
   exp_t sbq[$];

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (oValid !== 1'b0) begin
            checks++;
            if (sbq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pixel: oValid=%b at cycle %0d x=%0d y=%0d, required no output",
                        oValid, cyc, oX, oY);
            end else begin
               e = sbq.pop_front();
               if (oCidx !== e.c || oX !== e.x || oY !== e.y || 32'(cyc) != e.t) begin
                  errors++;
                  $display("FAIL pixel(%0d,%0d): got cidx=%0d x=%0d y=%0d cycle=%0d, required cidx=%0d x=%0d y=%0d cycle=%0d",
                           e.x, e.y, oCidx, oX, oY, cyc, e.c, e.x, e.y, e.t);
               end
            end
         end
      end
   endtask

   task automatic pix(input int x, input int y, input int c);
      iValid = 1'b1;
      iX = 10'(x);
      iY = 10'(y);
      sbq.push_back('{c: 6'(c), x: 10'(x), y: 10'(y), t: 32'(cyc + 3)});
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      iValid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic frame();
      iValid = 1'b0;
      iFrameStart = 1'b1;
      @(negedge clk);
      iFrameStart = 1'b0;
   endtask

   task automatic wr(input int sel, input int x, input int y, input bit en, input bit fs);
      iValid = 1'b0;
      iAttrWe = 1'b1;
      iAttrSel = 3'(sel);
      iAttrX = 11'(x);
      iAttrY = 11'(y);
      iAttrEn = en;
      iFrameStart = fs;
      @(negedge clk);
      iAttrWe = 1'b0;
      iFrameStart = 1'b0;
   endtask

   initial begin
      iValid = 0; iFrameStart = 0; iAttrWe = 0; iAttrEn = 0;
      iX = '0; iY = '0; iAttrSel = '0; iAttrX = '0; iAttrY = '0;
      for (int i = 0; i < N; i++) spr_fill[i] = '0;
      fork
         monitor();
         begin
            #200000;
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1);
         end
      join_none

      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("reset_oValid", 32'(oValid), 0);
      check("reset_oCidx", 32'(oCidx), 0);
      check("reset_oX", 32'(oX), 0);
      check("reset_oY", 32'(oY), 0);
      check("reset_oCollision", 32'(oCollision), 0);

      // Single sprite at (303,100)
      spr_fill[0] = 6'd5;
      wr(0, 303, 100, 1, 0);
      frame();
      pix(303, 100, 5);
      check("spr0_addr_origin", 32'(oSprAddr[0 +: AW]), 0);
      pix(304, 101, 40);
      check("spr0_addr_diag", 32'(oSprAddr[0 +: AW]), 35);
      idle(4);

      // Priority, transparency and collision
      wr(0, 10, 10, 1, 0);
      wr(1, 10, 10, 1, 0);
      spr_fill[0] = 6'd7;
      spr_fill[1] = 6'd9;
      frame();
      pix(10, 10, 7);
      pix(11, 10, 8);
      pix(44, 10, 3);
      idle(4);
      frame();
      check("collision_set", 32'(oCollision), 1);
      spr_fill[0] = 6'd0;
      pix(10, 10, 9);
      idle(4);
      frame();
      check("collision_clear", 32'(oCollision), 0);

      // Clipping at both screen edges
      wr(0, 0, 0, 0, 0);
      wr(1, 0, 0, 0, 0);
      wr(2, -20, 0, 1, 0);
      wr(3, 630, 100, 1, 0);
      spr_fill[2] = 6'd2;
      spr_fill[3] = 6'd4;
      frame();
      pix(0, 0, 22);
      check("spr2_addr_negx", 32'(oSprAddr[2*AW +: AW]), 20);
      pix(13, 0, 35);
      pix(14, 0, 3);
      pix(639, 100, 13);
      check("spr3_addr_right", 32'(oSprAddr[3*AW +: AW]), 9);
      pix(0, 100, 3);
      check("spr3_addr_nowrap", 32'(oSprAddr[3*AW +: AW]), 0);
      idle(4);

      // Mid-frame write is deferred to the next frame
      wr(2, 100, 50, 1, 0);
      pix(0, 0, 22);
      pix(100, 50, 3);
      idle(4);
      frame();
      pix(0, 0, 3);
      pix(100, 50, 2);
      idle(4);

      // Write coincident with frame start is committed
      spr_fill[1] = 6'd9;
      wr(1, 200, 200, 1, 1);
      pix(200, 200, 9);
      pix(233, 223, 56);
      check("spr1_addr_last", 32'(oSprAddr[1*AW +: AW]), 815);
      idle(4);

      // Reset with pixels in flight
      wr(0, 10, 10, 1, 0);
      wr(1, 10, 10, 1, 0);
      spr_fill[0] = 6'd7;
      frame();
      pix(10, 10, 7);
      idle(4);
      frame();
      check("collision_before_reset", 32'(oCollision), 1);
      iValid = 1'b1; iX = 10'd10; iY = 10'd10;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      iValid = 1'b0;
      check("inflight_reset_oValid", 32'(oValid), 0);
      @(negedge clk);
      rst = 1'b0;
      check("inflight_reset_oCollision", 32'(oCollision), 0);
      idle(4);
      pix(10, 10, 3);
      idle(4);
      frame();
      check("post_reset_collision", 32'(oCollision), 0);
      pix(10, 10, 3);
      idle(4);
      wr(0, 10, 10, 1, 0);
      frame();
      pix(10, 10, 7);
      idle(4);

      // Background scroll wrap
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (259) begin
         idle(4);
         frame();
      end
      pix(0, 0, 3);
      check("bg_addr_scroll259_a", 32'(oBgAddr), 259);
      pix(5, 1, 3);
      check("bg_addr_scroll259_b", 32'(oBgAddr), 264);
      idle(4);
      frame();
      pix(0, 0, 3);
      check("bg_addr_wrap_origin", 32'(oBgAddr), 0);
      pix(1, 1, 3);
      check("bg_addr_wrap_row1", 32'(oBgAddr), 261);
      idle(6);

      while (sbq.size() > 0) begin
         exp_t e;
         e = sbq.pop_front();
         checks++;
         errors++;
         $display("FAIL missing_pixel(%0d,%0d): got no output, required cidx=%0d at cycle %0d",
                  e.x, e.y, e.c, e.t);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sprite_layer_compositor.md
SPRITE_LAYER_COMPOSITOR -- requirements
Module: sprite_layer_compositor

Interface
REQ-001 Parameters SHALL be: NUM_SPRITES, default 4, sprite channel count (1-8); SPR_W, default 34, sprite width in pixels; SPR_H, default 24, sprite height; SCREEN_W, default 640; SCREEN_H, default 480; BG_W, default 260, background tile width (wraps horizontally); CIDX_W, default 6, colour-index width; SCROLL_DIV, default 50000, frames... cycles per background scroll step.
REQ-002 Reset SHALL be iReset, synchronous, active-high; clock SHALL be iClock.
REQ-003 iClock  in  1  pixel clock.
REQ-004 iReset  in  1  synchronous active-high reset.
REQ-005 iValid  in  1  pixel request strobe; iX/iY qualified by it.
REQ-006 iX, iY  in  10 each  screen coordinate of requested pixel.
REQ-007 iFrameStart  in  1  one-cycle pulse preceding pixel (0,0) of each frame.
REQ-008 iAttrWe  in  1  sprite-attribute shadow write strobe.
REQ-009 iAttrSel  in  3  sprite index written (values >= NUM_SPRITES ignored).
REQ-010 iAttrX, iAttrY  in  11 each, signed  sprite top-left position.
REQ-011 iAttrEn  in  1  sprite enable.
REQ-012 oSprAddr  out  NUM_SPRITES*ADDR_W, ADDR_W=clog2(SPR_W*SPR_H)  per-sprite pixelmap address.
REQ-013 iSprCidx  in  NUM_SPRITES*CIDX_W  per-sprite pixelmap data, one-cycle synchronous read.
REQ-014 oBgAddr  out  17  background pixelmap address; iBgCidx  in  CIDX_W  its data, one-cycle read.
REQ-015 oValid  out  1; oCidx  out  CIDX_W  composited colour index; oX, oY  out  10 each  echoed coordinate.
REQ-016 oCollision  out  1  sprite-0 overlap flag for the previous frame.

Function
REQ-017 Pipeline SHALL be fixed: iValid at cycle T -> oSprAddr/oBgAddr registered at T+1 -> pixelmap data sampled at T+2 -> oValid/oCidx/oX/oY registered at T+3; back-to-back pixels every cycle, no stalls.
REQ-018 Attribute writes SHALL go to shadow registers; shadows SHALL copy to active registers on the cycle iFrameStart is high; a write coincident with iFrameStart SHALL be committed in that same copy.
REQ-019 Sprite i hit SHALL be: active enable & iX >= X_i & iX < X_i+SPR_W & iY >= Y_i & iY < Y_i+SPR_H, compared signed at 12 bits; off-screen or negative positions SHALL be partially clipped, never wrap.
REQ-020 oSprAddr for a hit sprite SHALL be (iX-X_i)+(iY-Y_i)*SPR_W; for a non-hit sprite SHALL be 0.
REQ-021 oBgAddr SHALL be ((iX+scroll) mod BG_W)+iY*BG_W.
REQ-022 Scroll counter SHALL advance by 1 mod BG_W each SCROLL_DIV clock cycles, updating only on iFrameStart (pending step held until then).
REQ-023 Colour index 0 SHALL be transparent; oCidx SHALL be the lowest-index hit sprite with non-zero data, else iBgCidx.
REQ-024 A per-frame sticky flag SHALL set when sprite 0 and any other sprite are both hit with non-zero data on the same pixel; on iFrameStart oCollision SHALL load the flag and the flag SHALL clear (coincident set wins into the new frame's flag).
REQ-025 iValid low SHALL propagate as oValid low three cycles later; oCidx/oX/oY SHALL hold when oValid low.

Reset
REQ-026 On iReset: oValid=0, oCidx=0, oX=0, oY=0, oCollision=0, scroll=0, divider=0, all shadow and active enables=0, positions=0, collision flag=0, in-flight pipeline stages invalidated.
REQ-027 Reset mid-frame SHALL render background only until the next iFrameStart after new attribute writes.

Verification
REQ-028 Sprite 0 at (303,100) enabled, frame start, pixel (303,100) with sprite data 5 -> oCidx=5, oSprAddr0=0, oValid three cycles after iValid.
REQ-029 Sprites 0 and 1 both at (10,10), data 7 and 9 -> oCidx=7; sprite-0 data 0 -> oCidx=9; next frame start -> oCollision=1 only for first case's frame.
REQ-030 Sprite at X=-20, pixel (0,0) -> hit, oSprAddr=20; sprite at X=630, pixel (639,y) hit, no wrap to x=0.
REQ-031 Attribute write mid-frame -> composite unchanged until next iFrameStart, then new position used.
REQ-032 SCROLL_DIV=4, scroll=259 -> after step, pixel (0,0) oBgAddr=0 (wrap), pixel (1,1) oBgAddr=261.
REQ-033 iReset asserted with three pixels in flight -> no oValid for them, oCollision=0, output background only.
